// File: rtl/mem_bist_march_if.sv
// ---------------------------------------------------------------------------
// mem_bist_march_if
// Memory-side bus between the March C- BIST controller and the array under
// test (single write port, registered one-cycle-latency read port).
//
// Signals:
//   mem_write_data  WIDTH  write data towards the memory
//   mem_write_addr  ADDR   write address
//   mem_write_en    1      write enable
//   mem_read_addr   ADDR   read address
//   mem_read_data   WIDTH  registered read data from the memory
//
// Modports:
//   master - BIST controller side (drives addresses/data, consumes read data)
//   slave  - memory side
// ---------------------------------------------------------------------------
interface mem_bist_march_if #(
    parameter int WIDTH = 8,
    parameter int ADDR  = 4
);
    logic [WIDTH-1:0] mem_write_data;
    logic [ADDR-1:0]  mem_write_addr;
    logic             mem_write_en;
    logic [ADDR-1:0]  mem_read_addr;
    logic [WIDTH-1:0] mem_read_data;

    modport master (
        output mem_write_data,
        output mem_write_addr,
        output mem_write_en,
        output mem_read_addr,
        input  mem_read_data
    );

    modport slave (
        input  mem_write_data,
        input  mem_write_addr,
        input  mem_write_en,
        input  mem_read_addr,
        output mem_read_data
    );
endinterface

// File: rtl/mem_bist_march.sv
// ---------------------------------------------------------------------------
// mem_bist_march
// March C- built-in self-test controller for a WIDTH x DEPTH array with a
// registered (one-cycle latency) read port.
//
// Sequence: M0 w0 (up), M1 up(r0,w1), M2 up(r1,w0), M3 down(r0,w1),
//           M4 down(r1,w0), M5 r0 (up). 11*DEPTH busy cycles per run.
//
// Ports:
//   clk            rising-edge clock, shared with the memory
//   rst_n          asynchronous active-low reset
//   start          run request, accepted only in IDLE or DONE
//   busy           sequence in progress
//   done           run finished; held until the next accepted start
//   pass           valid while done; 1 = no mismatch seen
//   fail_addr      address of the first mismatch
//   fail_syndrome  read data XOR expected at the first mismatch
//   mem            memory bus (master modport of mem_bist_march_if)
//
// Build option:
//   MEM_BIST_ABORT_ON_FAIL_EN - when defined, the first mismatch ends the
//   run (DONE on the next cycle, no further writes). When undefined the
//   whole sequence always completes and only the first failure is logged.
// ---------------------------------------------------------------------------
module mem_bist_march #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int ADDR  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ADDR-1:0]   fail_addr,
    output logic [WIDTH-1:0]  fail_syndrome,
    mem_bist_march_if.master  mem
);

    typedef enum logic [2:0] {
        S_IDLE, S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_DONE
    } state_t;

    // In M5 the second phase is the compare-only (CMP) cycle.
    typedef enum logic {PH_RD, PH_WR} phase_t;

    typedef struct packed {
        state_t          st;
        phase_t          ph;
        logic [ADDR-1:0] addr;
    } pos_t;

    localparam logic [ADDR-1:0]  A_FIRST = '0;
    localparam logic [ADDR-1:0]  A_LAST  = ADDR'(DEPTH - 1);
    localparam logic [WIDTH-1:0] ZEROS   = '0;
    localparam logic [WIDTH-1:0] ONES    = '1;

    pos_t pos;
    pos_t nxt;
    logic start_ok;
    logic mismatch;
    logic nxt_we;
    logic [ADDR-1:0]  nxt_waddr;
    logic [ADDR-1:0]  nxt_raddr;
    logic [WIDTH-1:0] nxt_wdata;

    function automatic logic descending(input state_t s);
        return (s == S_M3) || (s == S_M4);
    endfunction

    // Value the read phase of an element expects; the write phase stores
    // its complement.
    function automatic logic [WIDTH-1:0] expected(input state_t s);
        return ((s == S_M2) || (s == S_M4)) ? ONES : ZEROS;
    endfunction

    // Position after one cycle of normal sequencing. IDLE and DONE hold.
    function automatic pos_t advance(input pos_t p);
        pos_t n;
        n = p;
        case (p.st)
            S_M0: begin
                if (p.addr == A_LAST) n = '{S_M1, PH_RD, A_FIRST};
                else                  n.addr = p.addr + 1'b1;
            end
            S_M1, S_M2, S_M3, S_M4: begin
                if (p.ph == PH_RD) begin
                    n.ph = PH_WR;
                end else begin
                    n.ph = PH_RD;
                    if (p.addr == (descending(p.st) ? A_FIRST : A_LAST)) begin
                        case (p.st)
                            S_M1:    n = '{S_M2, PH_RD, A_FIRST};
                            S_M2:    n = '{S_M3, PH_RD, A_LAST};
                            S_M3:    n = '{S_M4, PH_RD, A_LAST};
                            default: n = '{S_M5, PH_RD, A_FIRST};
                        endcase
                    end else if (descending(p.st)) begin
                        n.addr = p.addr - 1'b1;
                    end else begin
                        n.addr = p.addr + 1'b1;
                    end
                end
            end
            S_M5: begin
                if (p.ph == PH_RD)        n.ph = PH_WR;
                else if (p.addr == A_LAST) n = '{S_DONE, PH_RD, A_FIRST};
                else                      n = '{S_M5, PH_RD, p.addr + 1'b1};
            end
            default: n = p;
        endcase
        return n;
    endfunction

    // Next position and the memory-side values it implies. Everything here
    // lands in flops below, so start and mem_read_data never reach an
    // output combinationally.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        start_ok  = start && ((pos.st == S_IDLE) || (pos.st == S_DONE));
        mismatch  = (pos.ph == PH_WR) && (pos.st inside {[S_M1:S_M5]}) &&
                    (mem.mem_read_data != expected(pos.st));
        nxt       = advance(pos);
        nxt_we    = 1'b0;
        nxt_waddr = '0;
        nxt_raddr = '0;
        nxt_wdata = '0;

`ifdef MEM_BIST_ABORT_ON_FAIL_EN
        if (mismatch) nxt = '{S_DONE, PH_RD, A_FIRST};
`endif
        if (start_ok) nxt = '{S_M0, PH_RD, A_FIRST};

        if (nxt.st == S_M0) begin
            nxt_we    = 1'b1;
            nxt_waddr = nxt.addr;
        end else if (nxt.st inside {[S_M1:S_M5]}) begin
            // The read address is held through the write/compare phase.
            nxt_raddr = nxt.addr;
            if ((nxt.ph == PH_WR) && (nxt.st != S_M5)) begin
                nxt_we    = 1'b1;
                nxt_waddr = nxt.addr;
                nxt_wdata = ~expected(nxt.st);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos                <= '{S_IDLE, PH_RD, A_FIRST};
            busy               <= 1'b0;
            done               <= 1'b0;
            pass               <= 1'b0;
            fail_addr          <= '0;
            fail_syndrome      <= '0;
            mem.mem_write_data <= '0;
            mem.mem_write_addr <= '0;
            mem.mem_write_en   <= 1'b0;
            mem.mem_read_addr  <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every flop
            // samples pre-edge values regardless of statement order.
            pos                <= nxt;
            busy               <= (nxt.st != S_IDLE) && (nxt.st != S_DONE);
            done               <= (nxt.st == S_DONE);
            mem.mem_write_data <= nxt_wdata;
            mem.mem_write_addr <= nxt_waddr;
            mem.mem_write_en   <= nxt_we;
            mem.mem_read_addr  <= nxt_raddr;

            // pass doubles as "nothing captured yet" during a run.
            if (start_ok) begin
                pass          <= 1'b1;
                fail_addr     <= '0;
                fail_syndrome <= '0;
            end else if (mismatch && pass) begin
                pass          <= 1'b0;
                fail_addr     <= pos.addr;
                fail_syndrome <= mem.mem_read_data ^ expected(pos.st);
            end
        end
    end

endmodule

// File: tb/tb_mem_bist_march.sv
// ---------------------------------------------------------------------------
// tb_mem_bist_march
// Directed bench for mem_bist_march (WIDTH=8, DEPTH=16, ADDR=4) driving a
// behavioural registered-read memory with per-word stuck-at masks.
// Expected values are derived by hand from the March C- sequence. Build
// with or without MEM_BIST_ABORT_ON_FAIL_EN; fault-run lengths follow it.
// ---------------------------------------------------------------------------
module tb_mem_bist_march;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int ADDR  = 4;
    localparam int FULL  = 11 * DEPTH;   // 176
    localparam int LIMIT = 1000;

`ifdef MEM_BIST_ABORT_ON_FAIL_EN
    localparam int CYC_W5_SA0 = 60;      // M2 compare at address 5
    localparam int CYC_W0_SA1 = 18;      // M1 compare at address 0
`else
    localparam int CYC_W5_SA0 = FULL;
    localparam int CYC_W0_SA1 = FULL;
`endif

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             busy;
    logic             done;
    logic             pass;
    logic [ADDR-1:0]  fail_addr;
    logic [WIDTH-1:0] fail_syndrome;

    mem_bist_march_if #(.WIDTH(WIDTH), .ADDR(ADDR)) bus ();

    mem_bist_march #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .fail_addr     (fail_addr),
        .fail_syndrome (fail_syndrome),
        .mem           (bus)
    );

    // Memory model: write on the edge, read data registered on the edge.
    logic [WIDTH-1:0] mem_arr [DEPTH];
    logic [WIDTH-1:0] sa0     [DEPTH];
    logic [WIDTH-1:0] sa1     [DEPTH];

    always @(posedge clk) begin
        if (bus.mem_write_en) mem_arr[bus.mem_write_addr] <= bus.mem_write_data;
        bus.mem_read_data <= (mem_arr[bus.mem_read_addr] & ~sa0[bus.mem_read_addr])
                             | sa1[bus.mem_read_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;   // now in busy cycle 1
    endtask

    // Counts busy cycles from the current negedge until busy drops.
    task automatic wait_done(output int n);
        n = 0;
        while (busy && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic check_result(input string tag, input int n, input int exp_n,
                                input logic exp_pass, input logic [ADDR-1:0] exp_addr,
                                input logic [WIDTH-1:0] exp_syn);
        check({tag, " cycles"}, n, exp_n);
        check({tag, " done"}, done, 1'b1);
        check({tag, " busy"}, busy, 1'b0);
        check({tag, " pass"}, pass, exp_pass);
        check({tag, " fail_addr"}, fail_addr, exp_addr);
        check({tag, " syndrome"}, fail_syndrome, exp_syn);
        check({tag, " we idle"}, bus.mem_write_en, 1'b0);
    endtask

    task automatic clear_faults();
        for (int i = 0; i < DEPTH; i++) begin
            sa0[i] = '0;
            sa1[i] = '0;
        end
    endtask

    initial begin
        int n;
        start = 1'b0;
        rst_n = 1'b0;
        clear_faults();
        for (int i = 0; i < DEPTH; i++) mem_arr[i] = '0;

        // Reset state.
        #12;
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst pass", pass, 1'b0);
        check("rst fail_addr", fail_addr, 4'd0);
        check("rst syndrome", fail_syndrome, 8'h00);
        check("rst we", bus.mem_write_en, 1'b0);
        @(negedge clk) rst_n = 1'b1;

        // Fault-free run; also spot-check the first busy cycle (M0 w0 @0).
        pulse_start();
        check("c1 busy", busy, 1'b1);
        check("c1 we", bus.mem_write_en, 1'b1);
        check("c1 waddr", bus.mem_write_addr, 4'd0);
        check("c1 wdata", bus.mem_write_data, 8'h00);
        wait_done(n);
        check_result("clean", n, FULL, 1'b1, 4'd0, 8'h00);

        // Word 5 bit 3 stuck-at-0: first seen in M2 r1 at address 5.
        sa0[5] = 8'h08;
        pulse_start();
        check("sa0 restart done", done, 1'b0);
        wait_done(n);
        check_result("w5sa0", n, CYC_W5_SA0, 1'b0, 4'd5, 8'h08);
        clear_faults();

        // Word 0 bit 0 stuck-at-1: first seen in M1 r0 at address 0.
        sa1[0] = 8'h01;
        pulse_start();
        wait_done(n);
        check_result("w0sa1", n, CYC_W0_SA1, 1'b0, 4'd0, 8'h01);
        clear_faults();

        // Reset in busy cycle 50.
        pulse_start();
        repeat (49) @(negedge clk);
        check("pre-rst busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid-rst busy", busy, 1'b0);
        check("mid-rst done", done, 1'b0);
        check("mid-rst pass", pass, 1'b0);
        check("mid-rst we", bus.mem_write_en, 1'b0);
        check("mid-rst raddr", bus.mem_read_addr, 4'd0);
        @(negedge clk) rst_n = 1'b1;
        pulse_start();
        wait_done(n);
        check_result("post-rst", n, FULL, 1'b1, 4'd0, 8'h00);

        // start held high: one full run, then an immediate restart.
        @(negedge clk) start = 1'b1;
        @(negedge clk);
        wait_done(n);
        check_result("held", n, FULL, 1'b1, 4'd0, 8'h00);
        @(negedge clk);
        check("held restart busy", busy, 1'b1);
        check("held restart done", done, 1'b0);
        start = 1'b0;
        wait_done(n);
        check_result("held2", n, FULL, 1'b1, 4'd0, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
